iotdf_feeder: RTL and testbench

Byte-serializing transmitter that drives the IoT data-filter input port. Upstream logic pushes 128-bit words into a small FIFO. The block sends each word as 16 consecutive bytes on `in_en`/`iot_in`, most-significant byte first. It starts a new word only when the filter's `busy` is low, and presents a stable `fn_sel` for the duration of each word.

---
 rtl/iotdf_feeder.sv | 165 ++++++++++++++++
 tb/tb_iotdf_feeder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iotdf_feeder.sv
// Byte-serializing feeder for the IoT data filter: a small word FIFO drained MSB-first, 16 bytes per word.
// Optional macro FEEDER_ROUND_EN: 8-word rounds, fn_sel latched at round start, round_done pulse.
module iotdf_feeder #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [127:0] wr_data,
  output logic         full,
  output logic         ovf,
  input  logic [2:0]   cfg_fn,
  input  logic         busy,
  output logic         in_en,
  output logic [7:0]   iot_in,
  output logic [2:0]   fn_sel,
  output logic         round_done,
  output logic         idle,
  output logic [1:0]   dbg_state
);

  // Handshakes: a push is accepted on an edge where wr_en && !full (a push while full is
  // dropped and sets ovf); a word is popped on an edge where the FSM is IDLE, the FIFO is
  // non-empty and busy is low; once popped, all 16 bytes go out with in_en high, no stalls.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e        state_q;
  logic [127:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [127:0]  shift_q;
  logic [3:0]    byte_cnt_q;
  logic          in_en_q;
  logic [2:0]    fn_sel_q;
  logic          ovf_q;
  logic          push;
  logic          pop;

  assign full  = (count_q == FULL_CNT);
  assign push  = wr_en && !full;
  assign pop   = (state_q == S_IDLE) && (count_q != '0) && !busy;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; clearing the pointers and count is what discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      if (wr_en && full) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef FEEDER_ROUND_EN
  logic [2:0] word_cnt_q;
  logic       wrap_q;
  logic       round_done_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      in_en_q      <= 1'b0;
      fn_sel_q     <= '0;
`ifdef FEEDER_ROUND_EN
      word_cnt_q   <= '0;
      wrap_q       <= 1'b0;
      round_done_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q    <= mem_q[rd_ptr_q];
            byte_cnt_q <= '0;
            in_en_q    <= 1'b1;
            state_q    <= S_SEND;
`ifdef FEEDER_ROUND_EN
            word_cnt_q <= word_cnt_q + 3'd1;
            wrap_q     <= (word_cnt_q == 3'd7);
            if (word_cnt_q == 3'd0) begin
              fn_sel_q <= cfg_fn;
            end
`else
            fn_sel_q   <= cfg_fn;
`endif
          end
        end
        S_SEND: begin
          // busy is deliberately ignored here: the filter raises it during the last byte.
          shift_q    <= {shift_q[119:0], 8'h00};
          byte_cnt_q <= byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) begin
            in_en_q <= 1'b0;
            state_q <= S_GAP;
`ifdef FEEDER_ROUND_EN
            round_done_q <= wrap_q;
`endif
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
`ifdef FEEDER_ROUND_EN
          round_done_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_en     = in_en_q;
  assign iot_in    = in_en_q ? shift_q[127:120] : 8'h00;
  assign fn_sel    = fn_sel_q;
  assign ovf       = ovf_q;
  assign idle      = (state_q == S_IDLE) && (count_q == '0);
  assign dbg_state = state_q;

`ifdef FEEDER_ROUND_EN
  assign round_done = round_done_q;
`else
  assign round_done = 1'b0;
`endif

endmodule

// File: tb/tb_iotdf_feeder.sv
// Self-checking bench for iotdf_feeder: a negedge monitor reassembles words from the byte
// stream; scenario tasks compare against a word-level model (expected queue, occupancy, rounds).
`timescale 1ns/1ps
module tb_iotdf_feeder;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef FEEDER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic [2:0]   cfg_fn = '0;
  logic         busy = 1'b0;
  logic         full, ovf, in_en, round_done, idle;
  logic [7:0]   iot_in;
  logic [2:0]   fn_sel;
  logic [1:0]   dbg_state;

  iotdf_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .ovf(ovf),
    .cfg_fn(cfg_fn), .busy(busy), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
    .round_done(round_done), .idle(idle), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard (owned by the stimulus tasks)
  logic [127:0] exp_q[$];
  int           accepted = 0;
  logic         exp_ovf = 1'b0;

  // monitor-owned observations
  logic [127:0] rx_q[$];
  int           rx_start[$];
  logic [2:0]   rx_fn[$];
  logic [2:0]   rx_cfg[$];
  int           rd_q[$];
  int           starts = 0;
  int           zero_viol = 0;
  int           fn_viol = 0;
  int           aborted = 0;
  int           mb_idx = 0;
  int           mb_start = 0;
  logic [127:0] mb_acc = '0;
  logic [2:0]   mb_fn = '0;
  logic [2:0]   mb_cfg = '0;
  logic         gap_chk = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mb_idx = 0; gap_chk = 1'b0; starts = 0;
      rx_q.delete(); rx_start.delete(); rx_fn.delete(); rx_cfg.delete(); rd_q.delete();
    end else begin
      if (gap_chk) begin
        if (in_en !== 1'b0 || fn_sel !== mb_fn) fn_viol++;
        gap_chk = 1'b0;
      end
      if (round_done === 1'b1) rd_q.push_back(cyc);
      if (in_en === 1'b1) begin
        if (mb_idx == 0) begin
          mb_start = cyc; mb_fn = fn_sel; mb_cfg = cfg_fn; starts++;
        end else if (fn_sel !== mb_fn) begin
          fn_viol++;
        end
        mb_acc = {mb_acc[119:0], iot_in};
        mb_idx++;
        if (mb_idx == 16) begin
          rx_q.push_back(mb_acc); rx_start.push_back(mb_start);
          rx_fn.push_back(mb_fn); rx_cfg.push_back(mb_cfg);
          mb_idx = 0; gap_chk = 1'b1;
        end
      end else begin
        if (iot_in !== 8'h00) zero_viol++;
        if (mb_idx != 0) begin aborted++; mb_idx = 0; end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_push(input logic [127:0] w);
    wr_en = 1'b1;
    wr_data = w;
    if (accepted - starts < DEPTH) begin
      exp_q.push_back(w);
      accepted++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; busy = 1'b0; cfg_fn = '0; wr_data = '0;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete(); accepted = 0; exp_ovf = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; busy = 1'b0;
    tick(); tick();
    checks++; if (in_en !== 1'b0) begin failures++; $display("FAIL rst_in_en: got %b want 0", in_en); end
    checks++; if (iot_in !== 8'h00) begin failures++; $display("FAIL rst_iot_in: got %h want 00", iot_in); end
    checks++; if (fn_sel !== 3'd0) begin failures++; $display("FAIL rst_fn_sel: got %0d want 0", fn_sel); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b want 0", full); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    checks++; if (round_done !== 1'b0) begin failures++; $display("FAIL rst_round_done: got %b want 0", round_done); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL rst_idle: got %b want 1", idle); end
    rst = 1'b0;
    exp_q.delete(); accepted = 0; exp_ovf = 1'b0;
    repeat (3) tick();
    checks++; if (idle !== 1'b1 || in_en !== 1'b0) begin failures++; $display("FAIL post_rst_quiet: idle=%b in_en=%b want 1/0", idle, in_en); end
  endtask

  task automatic test_single_word();
    logic [127:0] w, got;
    int c0;
    w = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    do_reset();
    cfg_fn = 3'd5;
    c0 = cyc;
    drive_push(w);
    tick();
    wr_en = 1'b0;
    checks++; if (in_en !== 1'b0 || idle !== 1'b0) begin failures++; $display("FAIL single_early: in_en=%b idle=%b want 0/0", in_en, idle); end
    for (int i = 0; i < 40 && rx_q.size() < 1; i++) tick();
    checks++;
    if (rx_q.size() != 1) begin
      failures++; $display("FAIL single_timeout: got %0d words want 1", rx_q.size());
    end else begin
      got = rx_q[0];
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (got[127-8*k -: 8] !== 8'(k * 17)) begin
          failures++; $display("FAIL single_byte%0d: got %h want %h", k, got[127-8*k -: 8], 8'(k * 17));
        end
      end
      checks++; if (rx_start[0] != c0 + 2) begin failures++; $display("FAIL single_latency: got start %0d want %0d", rx_start[0], c0 + 2); end
      checks++; if (rx_fn[0] !== 3'd5) begin failures++; $display("FAIL single_fn: got %0d want 5", rx_fn[0]); end
      tick();
      checks++; if (in_en !== 1'b0 || iot_in !== 8'h00) begin failures++; $display("FAIL single_gap: in_en=%b iot_in=%h want 0/00", in_en, iot_in); end
      tick();
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b want 1", idle); end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin drive_push(rand128()); tick(); end
    wr_en = 1'b0;
    for (int i = 0; i < 80 && rx_q.size() < 3; i++) tick();
    checks++;
    if (rx_q.size() != 3) begin
      failures++; $display("FAIL b2b_timeout: got %0d words want 3", rx_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++; if (rx_q[j] !== exp_q[j]) begin failures++; $display("FAIL b2b_word%0d: got %h want %h", j, rx_q[j], exp_q[j]); end
      end
      checks++; if (rx_start[0] != c0 + 2) begin failures++; $display("FAIL b2b_first: got %0d want %0d", rx_start[0], c0 + 2); end
      for (int j = 1; j < 3; j++) begin
        checks++; if (rx_start[j] - rx_start[j-1] != 18) begin failures++; $display("FAIL b2b_spacing%0d: got %0d want 18", j, rx_start[j] - rx_start[j-1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int c0, bad, fall;
    do_reset();
    c0 = cyc;
    drive_push(rand128()); tick();
    drive_push(rand128()); tick();
    wr_en = 1'b0;
    for (int i = 0; i < 30 && cyc < c0 + 17; i++) tick();
    checks++; if (in_en !== 1'b1) begin failures++; $display("FAIL bp_byte16: in_en=%b want 1", in_en); end
    busy = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (in_en !== 1'b0) bad++; end
    busy = 1'b0;
    fall = cyc;
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d strobes want 0", bad); end
    for (int i = 0; i < 40 && rx_q.size() < 2; i++) tick();
    checks++;
    if (rx_q.size() != 2) begin
      failures++; $display("FAIL bp_timeout: got %0d words want 2", rx_q.size());
    end else begin
      checks++; if (rx_start[1] != fall + 1) begin failures++; $display("FAIL bp_restart: got %0d want %0d", rx_start[1], fall + 1); end
      for (int j = 0; j < 2; j++) begin
        checks++; if (rx_q[j] !== exp_q[j]) begin failures++; $display("FAIL bp_word%0d: got %h want %h", j, rx_q[j], exp_q[j]); end
      end
    end
  endtask

  task automatic test_full_overflow();
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_push(rand128());
      tick();
      checks++; if (full !== (accepted - starts == DEPTH)) begin failures++; $display("FAIL full_push%0d: got %b want %b", i + 1, full, (accepted - starts == DEPTH)); end
      checks++; if (ovf !== exp_ovf) begin failures++; $display("FAIL ovf_push%0d: got %b want %b", i + 1, ovf, exp_ovf); end
    end
    wr_en = 1'b0;
    repeat (3) tick();
    checks++; if (in_en !== 1'b0) begin failures++; $display("FAIL full_busy_hold: in_en=%b want 0", in_en); end
    busy = 1'b0;
    for (int i = 0; i < 120 && rx_q.size() < 4; i++) tick();
    repeat (30) tick();
    checks++;
    if (rx_q.size() != 4) begin
      failures++; $display("FAIL full_count: got %0d words want 4", rx_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++; if (rx_q[j] !== exp_q[j]) begin failures++; $display("FAIL full_word%0d: got %h want %h", j, rx_q[j], exp_q[j]); end
      end
    end
    checks++; if (ovf !== 1'b1 || full !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL full_end: ovf=%b full=%b idle=%b want 1/0/1", ovf, full, idle); end
  endtask

  task automatic test_round();
    int pushed, n_exp_rd;
    logic [2:0] exp_fn;
    int exp_rd[$];
    do_reset();
    cfg_fn = 3'd1;
    pushed = 0;
    for (int i = 0; i < 400 && rx_q.size() < 9; i++) begin
      if (pushed < 9 && accepted - starts < DEPTH) begin drive_push(rand128()); pushed++; end
      else wr_en = 1'b0;
      if (starts >= 2) cfg_fn = 3'd3;
      tick();
    end
    wr_en = 1'b0;
    repeat (4) tick();
    checks++;
    if (rx_q.size() != 9) begin
      failures++; $display("FAIL round_timeout: got %0d words want 9", rx_q.size());
    end else begin
      for (int j = 0; j < 9; j++) begin
        exp_fn = ROUND_EN ? rx_cfg[j - (j % 8)] : rx_cfg[j];
        checks++; if (rx_fn[j] !== exp_fn) begin failures++; $display("FAIL round_fn%0d: got %0d want %0d", j, rx_fn[j], exp_fn); end
        checks++; if (rx_q[j] !== exp_q[j]) begin failures++; $display("FAIL round_word%0d: got %h want %h", j, rx_q[j], exp_q[j]); end
        if (ROUND_EN && (j % 8 == 7)) exp_rd.push_back(rx_start[j] + 16);
      end
      n_exp_rd = exp_rd.size();
      checks++; if (rd_q.size() != n_exp_rd) begin failures++; $display("FAIL round_done_count: got %0d want %0d", rd_q.size(), n_exp_rd); end
      for (int j = 0; j < rd_q.size() && j < n_exp_rd; j++) begin
        checks++; if (rd_q[j] != exp_rd[j]) begin failures++; $display("FAIL round_done_cyc%0d: got %0d want %0d", j, rd_q[j], exp_rd[j]); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int c0;
    logic [127:0] w0;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin drive_push(rand128()); tick(); end
    wr_en = 1'b0;
    for (int i = 0; i < 20 && cyc < c0 + 9; i++) tick();
    w0 = exp_q[0];
    checks++; if (in_en !== 1'b1 || iot_in !== w0[71:64]) begin failures++; $display("FAIL mid_byte7: in_en=%b iot_in=%h want 1/%h", in_en, iot_in, w0[71:64]); end
    rst = 1'b1;
    #1;
    checks++; if (in_en !== 1'b0 || iot_in !== 8'h00) begin failures++; $display("FAIL mid_abort: in_en=%b iot_in=%h want 0/00", in_en, iot_in); end
    checks++; if (idle !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL mid_idle: idle=%b full=%b want 1/0", idle, full); end
    tick(); tick();
    rst = 1'b0;
    exp_q.delete(); accepted = 0; exp_ovf = 1'b0;
    repeat (40) tick();
    checks++; if (starts != 0 || rx_q.size() != 0) begin failures++; $display("FAIL mid_no_resend: starts=%0d words=%0d want 0/0", starts, rx_q.size()); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle_after: got %b want 1", idle); end
  endtask

  task automatic test_random();
    int n, n_exp_rd;
    logic [2:0] exp_fn;
    int exp_rd[$];
    do_reset();
    for (int i = 0; i < 400; i++) begin
      busy = ($urandom_range(0, 3) == 0);
      cfg_fn = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 2) drive_push(rand128());
      else wr_en = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 200 && rx_q.size() < exp_q.size(); i++) tick();
    repeat (4) tick();
    n = exp_q.size();
    checks++; if (rx_q.size() != n) begin failures++; $display("FAIL rand_count: got %0d words want %0d", rx_q.size(), n); end
    for (int j = 0; j < rx_q.size() && j < n; j++) begin
      exp_fn = ROUND_EN ? rx_cfg[j - (j % 8)] : rx_cfg[j];
      checks++; if (rx_q[j] !== exp_q[j]) begin failures++; $display("FAIL rand_word%0d: got %h want %h", j, rx_q[j], exp_q[j]); end
      checks++; if (rx_fn[j] !== exp_fn) begin failures++; $display("FAIL rand_fn%0d: got %0d want %0d", j, rx_fn[j], exp_fn); end
      if (ROUND_EN && (j % 8 == 7)) exp_rd.push_back(rx_start[j] + 16);
    end
    n_exp_rd = exp_rd.size();
    checks++; if (rd_q.size() != n_exp_rd) begin failures++; $display("FAIL rand_round_done: got %0d pulses want %0d", rd_q.size(), n_exp_rd); end
    checks++; if (ovf !== exp_ovf) begin failures++; $display("FAIL rand_ovf: got %b want %b", ovf, exp_ovf); end
    checks++; if (zero_viol != 0) begin failures++; $display("FAIL iot_in_zero: got %0d nonzero idle bytes want 0", zero_viol); end
    checks++; if (fn_viol != 0) begin failures++; $display("FAIL fn_stable: got %0d changes want 0", fn_viol); end
    checks++; if (aborted != 0) begin failures++; $display("FAIL word_unbroken: got %0d broken words want 0", aborted); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_full_overflow();
    test_round();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
